// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit datapath ALU: op encoding and default widths.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package alu_pkg;

    localparam int ALU_WIDTH  = 8;
    localparam int ALU_ADDR_W = 6;

    typedef enum logic [2:0] {
        OP_NOP = 3'b000,
        OP_ADD = 3'b001,
        OP_SUB = 3'b010,
        OP_AND = 3'b011,
        OP_NOT = 3'b100,
        OP_OR  = 3'b101,
        OP_EQ  = 3'b110,
        OP_BR  = 3'b111
    } op_e;

endpackage

// File: rtl/alu8_addsub.sv
// Combinational WIDTH-bit adder/subtractor; cout is carry on add, borrow on sub.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module alu8_addsub #(
    parameter int WIDTH = alu_pkg::ALU_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH:0] ext;

    // Zero-extended subtract leaves the top bit set exactly when a < b unsigned.
    always_comb begin
        if (sub) begin
            ext = {1'b0, a} - {1'b0, b};
        end else begin
            ext = {1'b0, a} + {1'b0, b};
        end
    end

    assign sum  = ext[WIDTH-1:0];
    assign cout = ext[WIDTH];

endmodule

// File: rtl/alu8_core.sv
// Registered 8-bit ALU with compare flag and conditional-branch strobe.
// Latency: 1 cycle, every output registered; one op accepted per cycle.
// Backpressure: none, no handshake; op sampled every rising edge.
module alu8_core
    import alu_pkg::*;
#(
    parameter int WIDTH  = ALU_WIDTH,
    parameter int ADDR_W = ALU_ADDR_W
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [WIDTH-1:0]  A,
    input  logic [WIDTH-1:0]  B,
    input  logic [ADDR_W-1:0] branch_addr,
    input  logic [2:0]        op,
    output logic [WIDTH-1:0]  out,
    output logic              co_flag,
    output logic              eq_flag,
    output logic              branch_flag
);

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             co;
        logic             eq;
        logic             br;
    } state_t;

    state_t           cur;
    state_t           nxt;
    op_e              op_dec;
    logic [WIDTH-1:0] as_sum;
    logic             as_cout;
    logic             a_eq_b;

    assign op_dec = op_e'(op);
    assign a_eq_b = (A == B);

    alu8_addsub #(
        .WIDTH (WIDTH)
    ) u_addsub (
        .a    (A),
        .b    (B),
        .sub  (op_dec == OP_SUB),
        .sum  (as_sum),
        .cout (as_cout)
    );

    // Default is hold with the branch strobe dropped; each op overrides what it owns.
    always_comb begin
        nxt    = cur;
        nxt.br = 1'b0;
        case (op_dec)
            OP_NOP: begin
                nxt.br = 1'b0;
            end
            OP_ADD, OP_SUB: begin
                nxt.res = as_sum;
                nxt.co  = as_cout;
            end
            OP_AND: begin
                nxt.res = A & B;
                nxt.co  = 1'b0;
            end
            OP_NOT: begin
                nxt.res = ~A;
                nxt.co  = 1'b0;
            end
            OP_OR: begin
                nxt.res = A | B;
                nxt.co  = 1'b0;
            end
            OP_EQ: begin
                nxt.res = WIDTH'(a_eq_b);
                nxt.eq  = a_eq_b;
                nxt.co  = 1'b0;
            end
            OP_BR: begin
                // Condition is the flag registered before this edge, so EQ then BR chains.
                nxt.co  = 1'b0;
                nxt.br  = cur.eq;
                nxt.res = cur.eq ? WIDTH'(branch_addr) : '0;
            end
            default: begin
                nxt.br = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cur <= '0;
        end else begin
            cur <= nxt;
        end
    end

    assign out         = cur.res;
    assign co_flag     = cur.co;
    assign eq_flag     = cur.eq;
    assign branch_flag = cur.br;

endmodule

// File: tb/tb_alu8_core.sv
// Directed self-checking bench for alu8_core with hand-computed expectations.
module tb_alu8_core;

    logic       CLK;
    logic       RST_N;
    logic [7:0] A;
    logic [7:0] B;
    logic [5:0] branch_addr;
    logic [2:0] op;
    logic [7:0] out;
    logic       co_flag;
    logic       eq_flag;
    logic       branch_flag;

    int total;
    int bad;

    alu8_core #(
        .WIDTH  (8),
        .ADDR_W (6)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .A           (A),
        .B           (B),
        .branch_addr (branch_addr),
        .op          (op),
        .out         (out),
        .co_flag     (co_flag),
        .eq_flag     (eq_flag),
        .branch_flag (branch_flag)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive inputs away from the edge, clock once, then settle before sampling.
    task automatic step(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                        input logic [5:0] ba);
        op          = o;
        A           = a;
        B           = b;
        branch_addr = ba;
        @(posedge CLK);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [7:0] e_out, input logic e_co,
                           input logic e_eq, input logic e_br);
        chk({tag, ".out"}, {24'd0, out}, {24'd0, e_out});
        chk({tag, ".co"},  {31'd0, co_flag}, {31'd0, e_co});
        chk({tag, ".eq"},  {31'd0, eq_flag}, {31'd0, e_eq});
        chk({tag, ".br"},  {31'd0, branch_flag}, {31'd0, e_br});
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        RST_N       = 1'b0;
        op          = 3'b000;
        A           = 8'd0;
        B           = 8'd0;
        branch_addr = 6'd0;

        // Reset held with ADD 5+5 presented: outputs must stay cleared.
        @(posedge CLK);
        #1;
        step(3'b001, 8'd5, 8'd5, 6'd0);
        step(3'b001, 8'd5, 8'd5, 6'd0);
        chk_all("rst_hold", 8'd0, 1'b0, 1'b0, 1'b0);
        RST_N = 1'b1;
        step(3'b001, 8'd5, 8'd5, 6'd0);
        chk_all("rst_release_add", 8'd10, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset mid-cycle clears without a clock edge.
        step(3'b001, 8'd255, 8'd255, 6'd0);
        chk_all("pre_async", 8'd254, 1'b1, 1'b0, 1'b0);
        #2;
        RST_N = 1'b0;
        #1;
        chk_all("async_rst", 8'd0, 1'b0, 1'b0, 1'b0);
        #1;
        RST_N = 1'b1;

        step(3'b001, 8'd18, 8'd3, 6'd0);
        chk_all("add_18_3", 8'd21, 1'b0, 1'b0, 1'b0);
        step(3'b001, 8'd255, 8'd255, 6'd0);
        chk_all("add_255_255", 8'd254, 1'b1, 1'b0, 1'b0);
        step(3'b001, 8'd0, 8'd1, 6'd0);
        chk_all("add_0_1", 8'd1, 1'b0, 1'b0, 1'b0);

        step(3'b010, 8'd0, 8'd7, 6'd0);
        chk_all("sub_0_7", 8'd249, 1'b1, 1'b0, 1'b0);
        step(3'b000, 8'd9, 8'd9, 6'd0);
        chk_all("nop_hold", 8'd249, 1'b1, 1'b0, 1'b0);
        step(3'b010, 8'd7, 8'd7, 6'd0);
        chk_all("sub_7_7", 8'd0, 1'b0, 1'b0, 1'b0);

        step(3'b001, 8'd200, 8'd100, 6'd0);
        chk_all("add_carry", 8'd44, 1'b1, 1'b0, 1'b0);
        step(3'b011, 8'h05, 8'h15, 6'd0);
        chk_all("and_05_15", 8'h05, 1'b0, 1'b0, 1'b0);
        step(3'b011, 8'h00, 8'hFF, 6'd0);
        chk_all("and_00_ff", 8'h00, 1'b0, 1'b0, 1'b0);
        step(3'b011, 8'hFF, 8'hFF, 6'd0);
        chk_all("and_ff_ff", 8'hFF, 1'b0, 1'b0, 1'b0);
        step(3'b100, 8'h00, 8'h5A, 6'd0);
        chk_all("not_00", 8'hFF, 1'b0, 1'b0, 1'b0);
        step(3'b100, 8'hA5, 8'hFF, 6'd0);
        chk_all("not_a5", 8'h5A, 1'b0, 1'b0, 1'b0);
        step(3'b101, 8'h15, 8'h03, 6'd0);
        chk_all("or_15_03", 8'h17, 1'b0, 1'b0, 1'b0);
        step(3'b101, 8'hFF, 8'h00, 6'd0);
        chk_all("or_ff_00", 8'hFF, 1'b0, 1'b0, 1'b0);

        // Branch before any compare: eq is 0, so not taken.
        step(3'b111, 8'd0, 8'd0, 6'h3F);
        chk_all("br_no_eq", 8'd0, 1'b0, 1'b0, 1'b0);

        // Taken branch directly after EQ, then back-to-back, then NOP.
        step(3'b110, 8'h15, 8'h15, 6'd0);
        chk_all("eq_match", 8'd1, 1'b0, 1'b1, 1'b0);
        step(3'b111, 8'h00, 8'h00, 6'b100100);
        chk_all("br_taken", 8'h24, 1'b0, 1'b1, 1'b1);
        step(3'b111, 8'h00, 8'h00, 6'h3F);
        chk_all("br_taken_b2b", 8'h3F, 1'b0, 1'b1, 1'b1);
        step(3'b000, 8'h00, 8'h00, 6'd0);
        chk_all("nop_after_br", 8'h3F, 1'b0, 1'b1, 1'b0);

        // eq persists across unrelated ops; branch later still taken.
        step(3'b001, 8'd255, 8'd1, 6'd0);
        chk_all("add_keeps_eq", 8'd0, 1'b1, 1'b1, 1'b0);
        step(3'b111, 8'h00, 8'h00, 6'h11);
        chk_all("br_late", 8'h11, 1'b0, 1'b1, 1'b1);
        step(3'b011, 8'hF0, 8'h3C, 6'd0);
        chk_all("and_drops_br", 8'h30, 1'b0, 1'b1, 1'b0);

        // Not-taken path.
        step(3'b110, 8'h17, 8'h15, 6'd0);
        chk_all("eq_miss", 8'd0, 1'b0, 1'b0, 1'b0);
        step(3'b111, 8'h00, 8'h00, 6'b101100);
        chk_all("br_not_taken", 8'd0, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a taken-branch sequence discards everything.
        step(3'b110, 8'h42, 8'h42, 6'd0);
        step(3'b111, 8'h00, 8'h00, 6'h2A);
        chk_all("br_pre_rst", 8'h2A, 1'b0, 1'b1, 1'b1);
        #2;
        RST_N = 1'b0;
        #1;
        chk_all("rst_mid_br", 8'd0, 1'b0, 1'b0, 1'b0);
        #1;
        RST_N = 1'b1;
        step(3'b111, 8'h00, 8'h00, 6'h2A);
        chk_all("br_after_rst", 8'd0, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
